// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Serialises icache refills and dcache refills/write-backs onto one
//            fixed-latency memory port; dcache-first with an icache turn flag.
// Revision : 1.0  initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int                 c_CNT_W = 4;
  localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MEM_LAT);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt;
  logic                r_i_turn, w_i_turn;
  logic                w_mem_en, w_mem_we, w_i_ack, w_d_ack, w_busy;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [LINE_W-1:0]   w_mem_wdata, w_i_rdata, w_d_rdata;
  logic                w_i_elig, w_d_elig;

  // A requester whose ack is still high was just served and must not be re-granted.
  assign w_i_elig = i_req && !i_ack;
  assign w_d_elig = d_req && !d_ack;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_i_turn    = r_i_turn;
    w_mem_en    = 1'b0;
    w_mem_we    = mem_we;
    w_mem_addr  = mem_addr;
    w_mem_wdata = mem_wdata;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_i_rdata   = i_rdata;
    w_d_rdata   = d_rdata;
    w_busy      = busy;
    case (r_state)
      ST_IDLE: begin
        if (w_i_elig && (!w_d_elig || r_i_turn)) begin
          w_state    = ST_IBUSY;
          w_mem_en   = 1'b1;
          w_mem_we   = 1'b0;
          w_mem_addr = i_addr;
          w_busy     = 1'b1;
          w_cnt      = c_LAT;
          w_i_turn   = 1'b0;
        end else if (w_d_elig) begin
          w_state     = ST_DBUSY;
          w_mem_en    = 1'b1;
          w_mem_we    = d_we;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_busy      = 1'b1;
          w_cnt       = c_LAT;
          // icache was passed over; it wins the next contested grant
          if (w_i_elig) begin
            w_i_turn = 1'b1;
          end
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (r_cnt == '0) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          if (r_state == ST_IBUSY) begin
            w_i_ack   = 1'b1;
            w_i_rdata = mem_rdata;
          end else begin
            w_d_ack = 1'b1;
            if (!mem_we) begin
              w_d_rdata = mem_rdata;
            end
          end
        end else begin
          w_cnt = r_cnt - c_ONE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_i_turn  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_i_turn  <= w_i_turn;
      mem_en    <= w_mem_en;
      mem_we    <= w_mem_we;
      mem_addr  <= w_mem_addr;
      mem_wdata <= w_mem_wdata;
      i_ack     <= w_i_ack;
      d_ack     <= w_d_ack;
      i_rdata   <= w_i_rdata;
      d_rdata   <= w_d_rdata;
      busy      <= w_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// Directed bench for cache_mem_arbiter: a MEM_LAT=4 instance and a MEM_LAT=1
// instance, each with a memory model that drives data only in its valid cycle.
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] GARBAGE = {4{32'h5A5AA5A5}};
  localparam logic [LW-1:0] LINE_I  = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
  localparam logic [LW-1:0] LINE_I2 = {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
  localparam logic [LW-1:0] LINE_D  = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
  localparam logic [LW-1:0] LINE_D2 = {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  // MEM_LAT=4 instance signals
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, mem_en, mem_we, busy;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] rdata_val = '0;
  logic [3:0]    en_pipe = '0;

  // MEM_LAT=1 instance signals
  logic          d_req1 = 1'b0;
  logic [AW-1:0] d_addr1 = '0;
  logic          i_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic [LW-1:0] i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;
  logic [LW-1:0] rdata1_val = '0;
  logic          en1_q = 1'b0;

  always #5 clk = ~clk;

  // Data is valid only during the cycle MEM_LAT cycles after the mem_en cycle.
  always @(posedge clk) en_pipe <= {en_pipe[2:0], mem_en};
  assign mem_rdata = en_pipe[3] ? rdata_val : GARBAGE;
  always @(posedge clk) en1_q <= mem_en1;
  assign mem_rdata1 = en1_q ? rdata1_val : GARBAGE;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(1'b0), .i_addr('0), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata('0),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 28'h0000777; d_addr = 28'h0000888;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctrl edge=%0d got en=%b busy=%b iack=%b dack=%b exp all 0",
                 k, mem_en, busy, i_ack, d_ack);
      end
    end
    checks++;
    if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h we=%b wdata=%h irdata=%h drdata=%h exp all 0",
               mem_addr, mem_we, mem_wdata, i_rdata, d_rdata);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mem_en !== 1'b1 || busy !== 1'b1 || mem_addr !== 28'h0000888) begin
      failures++;
      $display("FAIL reset_first_grant got en=%b busy=%b addr=%h exp en=1 busy=1 addr=0000888",
               mem_en, busy, mem_addr);
    end
    i_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
  endtask

  task automatic test_icache_read();
    i_addr = 28'h0000123; i_req = 1'b1; rdata_val = LINE_I;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 28'h0000123 || busy !== 1'b1 || i_ack !== 1'b0) begin
      failures++;
      $display("FAIL icache_e0 got en=%b we=%b addr=%h busy=%b iack=%b exp 1 0 0000123 1 0",
               mem_en, mem_we, mem_addr, busy, i_ack);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || busy !== 1'b1 || i_ack !== 1'b0 || mem_addr !== 28'h0000123) begin
        failures++;
        $display("FAIL icache_wait E%0d got en=%b busy=%b iack=%b addr=%h exp 0 1 0 0000123",
                 k, mem_en, busy, i_ack, mem_addr);
      end
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== LINE_I || busy !== 1'b0 || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL icache_e5 got iack=%b irdata=%h busy=%b dack=%b exp 1 %h 0 0",
               i_ack, i_rdata, busy, d_ack, LINE_I);
    end
    tick();
    checks++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0 || i_rdata !== LINE_I) begin
      failures++;
      $display("FAIL icache_ack_mask got iack=%b en=%b busy=%b irdata=%h exp 0 0 0 %h",
               i_ack, mem_en, busy, i_rdata, LINE_I);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL icache_no_regrant got en=%b busy=%b exp 0 0", mem_en, busy);
    end
  endtask

  task automatic test_priority();
    i_addr = 28'h0000111; d_addr = 28'h0000222; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1; rdata_val = LINE_D;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 28'h0000222 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL prio_dfirst got en=%b addr=%h we=%b exp 1 0000222 0", mem_en, mem_addr, mem_we);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
        failures++;
        $display("FAIL prio_wait1 E%0d got en=%b dack=%b iack=%b exp 0 0 0", k, mem_en, d_ack, i_ack);
      end
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== LINE_D || i_ack !== 1'b0) begin
      failures++;
      $display("FAIL prio_dack got dack=%b drdata=%h iack=%b exp 1 %h 0", d_ack, d_rdata, i_ack, LINE_D);
    end
    rdata_val = LINE_I2;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 28'h0000111 || mem_we !== 1'b0 || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL prio_igrant_e6 got en=%b addr=%h we=%b dack=%b exp 1 0000111 0 0",
               mem_en, mem_addr, mem_we, d_ack);
    end
    for (int k = 0; k < 4; k++) tick();
    tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== LINE_I2 || d_rdata !== LINE_D) begin
      failures++;
      $display("FAIL prio_iack got iack=%b irdata=%h drdata=%h exp 1 %h %h",
               i_ack, i_rdata, d_rdata, LINE_I2, LINE_D);
    end
    rdata_val = LINE_D2;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 28'h0000222) begin
      failures++;
      $display("FAIL prio_dgrant_e12 got en=%b addr=%h exp 1 0000222", mem_en, mem_addr);
    end
    i_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== LINE_D2) begin
      failures++;
      $display("FAIL prio_dack2 got dack=%b drdata=%h exp 1 %h", d_ack, d_rdata, LINE_D2);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_turn();
    i_addr = 28'h00000AB; d_addr = 28'h00000CD; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1; rdata_val = LINE_D;
    tick();
    checks++;
    if (mem_addr !== 28'h00000CD || mem_en !== 1'b1) begin
      failures++;
      $display("FAIL turn_dfirst got addr=%h en=%b exp 00000CD 1", mem_addr, mem_en);
    end
    i_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    d_req = 1'b0;
    tick();
    i_req = 1'b1; d_req = 1'b1; rdata_val = LINE_I;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 28'h00000AB || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL turn_icache_wins got en=%b addr=%h we=%b exp 1 00000AB 0", mem_en, mem_addr, mem_we);
    end
    d_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== LINE_I) begin
      failures++;
      $display("FAIL turn_iack got iack=%b irdata=%h exp 1 %h", i_ack, i_rdata, LINE_I);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_write_back();
    d_we = 1'b1; d_addr = 28'h00000A0; d_wdata = '1; d_req = 1'b1; rdata_val = LINE_I2;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 28'h00000A0 || mem_wdata !== {LW{1'b1}}) begin
      failures++;
      $display("FAIL wb_e0 got en=%b we=%b addr=%h wdata=%h exp 1 1 00000A0 all-ones",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    d_req = 1'b0; d_we = 1'b0; d_addr = 28'h0000005; d_wdata = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 28'h00000A0 || mem_wdata !== {LW{1'b1}}) begin
        failures++;
        $display("FAIL wb_hold E%0d got en=%b we=%b addr=%h wdata=%h exp 0 1 00000A0 all-ones",
                 k, mem_en, mem_we, mem_addr, mem_wdata);
      end
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== LINE_D || busy !== 1'b0) begin
      failures++;
      $display("FAIL wb_ack got dack=%b drdata=%h busy=%b exp 1 %h 0", d_ack, d_rdata, busy, LINE_D);
    end
    tick();
    checks++;
    if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL wb_after got dack=%b en=%b exp 0 0", d_ack, mem_en);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    d_req = 1'b1; d_we = 1'b0; d_addr = 28'h0000333; rdata_val = LINE_I;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0 || mem_addr !== '0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL rstmid_e2 got en=%b busy=%b dack=%b addr=%h drdata=%h exp all 0",
               mem_en, busy, d_ack, mem_addr, d_rdata);
    end
    d_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || d_ack !== 1'b0 || i_rdata !== '0) begin
      failures++;
      $display("FAIL rstmid_e3 got busy=%b dack=%b irdata=%h exp 0 0 0", busy, d_ack, i_rdata);
    end
    reset = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL rstmid_no_ack got active_cycles=%0d drdata=%h exp 0 0", acks, d_rdata);
    end
  endtask

  task automatic test_lat1();
    d_req1 = 1'b1; d_addr1 = 28'h0000044; rdata1_val = LINE_D2;
    tick();
    checks++;
    if (mem_en1 !== 1'b1 || busy1 !== 1'b1 || mem_addr1 !== 28'h0000044 || mem_we1 !== 1'b0 || mem_wdata1 !== '0) begin
      failures++;
      $display("FAIL lat1_e0 got en=%b busy=%b addr=%h we=%b wdata=%h exp 1 1 0000044 0 0",
               mem_en1, busy1, mem_addr1, mem_we1, mem_wdata1);
    end
    tick();
    checks++;
    if (mem_en1 !== 1'b0 || busy1 !== 1'b1 || d_ack1 !== 1'b0) begin
      failures++;
      $display("FAIL lat1_e1 got en=%b busy=%b dack=%b exp 0 1 0", mem_en1, busy1, d_ack1);
    end
    tick();
    checks++;
    if (d_ack1 !== 1'b1 || d_rdata1 !== LINE_D2 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL lat1_e2 got dack=%b drdata=%h busy=%b exp 1 %h 0", d_ack1, d_rdata1, busy1, LINE_D2);
    end
    d_req1 = 1'b0;
    tick();
    checks++;
    if (d_ack1 !== 1'b0 || mem_en1 !== 1'b0 || i_ack1 !== 1'b0 || i_rdata1 !== '0) begin
      failures++;
      $display("FAIL lat1_e3 got dack=%b en=%b iack=%b irdata=%h exp 0 0 0 0",
               d_ack1, mem_en1, i_ack1, i_rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_priority();
    test_turn();
    test_write_back();
    test_reset_mid();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path of the pipelined core.
- The two caches are the sources of the pipeline's ihit/dhit stall signals.
- Serialises line transactions and counts the fixed memory latency.
- Returns line data and a one-cycle acknowledge to the requesting cache.
- Uses dcache-first priority, with an anti-starvation turn for the icache.

Parameters:
ADDR_W, 28, line-address width (byte address >> 4)
LINE_W, 128, cache line width in bits
MEM_LAT, 4, memory latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-low
i_req  in  1  icache line-read request, held until i_ack
i_addr  in  ADDR_W  icache line address
i_ack  out  1  one-cycle pulse: i_rdata valid, transaction done
i_rdata  out  LINE_W  line returned to icache
d_req  in  1  dcache request, held until d_ack
d_we  in  1  1 = line write-back, 0 = line read
d_addr  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  write-back line
d_ack  out  1  one-cycle pulse: transaction done
d_rdata  out  LINE_W  line returned to dcache (reads only)
mem_en  out  1  one-cycle memory command strobe
mem_we  out  1  memory write enable, qualifies mem_en
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  LINE_W  memory write data
mem_rdata  in  LINE_W  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle
busy  out  1  transaction in flight

Behaviour:
- All outputs are registered.
- Reset: when reset==0 at a rising edge:
  - state=IDLE, latency counter=0, turn flag i_turn=0.
  - mem_en, mem_we, mem_addr, mem_wdata, i_ack, d_ack, i_rdata, d_rdata and busy all go to 0.
  - Reset mid-transaction abandons it: no ack is issued, and the memory response is ignored.
- States: IDLE, IBUSY, DBUSY.
- IDLE, per edge:
  - Eligible requesters: i_req && !i_ack, and d_req && !d_ack. A requester whose ack is high this cycle is masked, which prevents a double grant.
  - Both eligible: grant icache if i_turn==1, else dcache.
  - One eligible: grant it.
  - Neither: stay in IDLE.
- On grant (edge E0):
  - Capture address, we (icache: we=0) and wdata into mem_addr, mem_we and mem_wdata.
  - mem_en=1 for the cycle E0..E1 only.
  - busy=1, counter=MEM_LAT, go to IBUSY or DBUSY.
- i_turn update:
  - Set to 1 when the dcache is granted while i_req is eligible.
  - Cleared to 0 when the icache is granted.
- IBUSY/DBUSY:
  - mem_addr, mem_we and mem_wdata are held stable.
  - mem_en=0 after the first cycle.
  - The counter decrements each edge after E0.
  - At the edge where the counter reaches 0 (edge E(MEM_LAT+1)):
    - Capture mem_rdata into i_rdata (IBUSY) or d_rdata (DBUSY read only; a write leaves d_rdata unchanged).
    - Pulse the matching ack for one cycle.
    - busy=0, return to IDLE.
- Latency: request sampled at E0 -> ack high during E(MEM_LAT+1)..E(MEM_LAT+2). Back-to-back grants are spaced MEM_LAT+2 edges apart.
- Inputs are not sampled in BUSY states. A requester dropping req mid-transaction does not abort it; the ack is still pulsed.
- i_rdata and d_rdata hold their values between completions.
- mem_en is never asserted while busy=1 from a previous grant.

Test Plan:
- Reset: hold reset=0 for 3 edges with i_req=d_req=1 -> all outputs 0, no mem_en. Release reset -> first grant at the next edge.
- Single icache read, MEM_LAT=4, i_addr=0x0000123, memory returns 0xDEADBEEF_...: mem_en for 1 cycle after E0 with mem_addr=0x0000123, mem_we=0 -> i_ack high exactly during E5..E6 with i_rdata equal to the returned line; busy high E0..E5.
- Dcache write-back, d_we=1, d_addr=0x00000A0, d_wdata=all-ones: mem_we=1, mem_wdata=all-ones held through the transaction -> d_ack at E5; d_rdata unchanged.
- Simultaneous i_req and d_req at E0 -> dcache served first, i_turn=1. d_req reasserted immediately with i_req still high -> icache granted next at E6, then the dcache.
- Ack masking: requester holds req high during its ack cycle -> no second mem_en; exactly one transaction per req assertion.
- Reset asserted at E2 of a DBUSY read -> outputs 0 at E3, no d_ack. A fresh request after release completes normally with MEM_LAT=1 (ack at E2).
